y_result_streamer: RTL and testbench

Downstream stage of the 8x8 matrix multiplier that computes the intermediate and final products of Y = D·X·Dᵀ. It captures the 64 result words when the multiplier asserts its done level, then emits them one word at a time over a valid/ready stream. The order is row-major, or column-major when transposed, so the next multiply pass or an external sink can consume them serially.

---
 rtl/y_result_streamer.sv | 180 ++++++++++++++++++
 tb/tb_y_result_streamer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y_result_streamer.sv
// y_result_streamer
//   Captures the 64-element result matrix of the 8x8 multiplier when its done
//   level rises. It then streams the elements one per transfer over a
//   valid/ready interface, in row-major order or, if transposed, column-major.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   done_in    : multiplier done level (only its rising edge matters)
//   y_flat     : 64 result words, element (r,c) at [(8r+c)*W +: W]
//   transpose  : emit order, sampled at capture (1 = column-major)
//   out_data   : current element
//   out_valid  : out_data is valid
//   out_ready  : sink accepts out_data this cycle
//   out_row    : row index of out_data
//   out_col    : column index of out_data
//   out_last   : high with the 64th element
//   busy       : high while streaming
//   overrun    : sticky, a capture request arrived mid-stream and was dropped
module y_result_streamer #(
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_in,
  input  logic [64*(2*N+3)-1:0]     y_flat,
  input  logic                      transpose,
  output logic [2*N+2:0]            out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_row,
  output logic [2:0]                out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int W = 2*N+3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [5:0]     idx_r;
  logic [5:0]     idx_nx_s;
  logic           done_q_r;
  logic           mode_r;
  logic           overrun_r;
  logic [W-1:0]   buf_r [64];

  logic           rise_s;
  logic           xfer_s;
  logic           final_s;
  logic           capture_s;
  logic [2:0]     row_s;
  logic [2:0]     col_s;

  // Capture decode: a rise is accepted when idle or on the final transfer,
  // which lets back-to-back matrices stream without an idle gap.
  always_comb begin
    rise_s    = done_in & ~done_q_r;
    xfer_s    = (state_r == STREAM) & out_ready;
    final_s   = xfer_s & (idx_r == 6'd63);
    capture_s = rise_s & ((state_r == IDLE) | final_s);
  end

  // Next-state and index logic.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_nx_s = STREAM;
          idx_nx_s   = 6'd0;
        end else begin
          state_nx_s = IDLE;
          idx_nx_s   = idx_r;
        end
      end
      STREAM: begin
        if (final_s) begin
          // Reload on a coincident rise, otherwise return to idle.
          state_nx_s = capture_s ? STREAM : IDLE;
          idx_nx_s   = 6'd0;
        end else if (xfer_s) begin
          state_nx_s = STREAM;
          idx_nx_s   = idx_r + 6'd1;
        end else begin
          state_nx_s = STREAM;
          idx_nx_s   = idx_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = 6'd0;
      end
    endcase
  end

  // Control state registers: FSM, index, done edge detector, mode, overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 6'd0;
      done_q_r  <= 1'b0;
      mode_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      idx_r    <= idx_nx_s;
      done_q_r <= done_in;
      if (capture_s) begin
        mode_r <= transpose;
      end else begin
        mode_r <= mode_r;
      end
      // A rise mid-stream (not on the final transfer) is dropped and flagged.
      if (rise_s && (state_r == STREAM) && !final_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Result buffer; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int i = 0; i < 64; i++) begin
        buf_r[i] <= y_flat[i*W +: W];
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        buf_r[i] <= buf_r[i];
      end
    end
  end

  // Element coordinates: the index is swapped into (row, col) in column-major mode.
  always_comb begin
    if (mode_r) begin
      row_s = idx_r[2:0];
      col_s = idx_r[5:3];
    end else begin
      row_s = idx_r[5:3];
      col_s = idx_r[2:0];
    end
  end

  // Output mux driven purely from registered state.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_row   = 3'd0;
    out_col   = 3'd0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (state_r == STREAM) begin
      out_data  = buf_r[{row_s, col_s}];
      out_valid = 1'b1;
      out_row   = row_s;
      out_col   = col_s;
      out_last  = (idx_r == 6'd63);
      busy      = 1'b1;
    end else begin
      out_data  = '0;
      out_valid = 1'b0;
      out_row   = 3'd0;
      out_col   = 3'd0;
      out_last  = 1'b0;
      busy      = 1'b0;
    end
    overrun = overrun_r;
  end

endmodule

// File: tb/tb_y_result_streamer.sv
// Testbench for y_result_streamer: table-driven full-matrix streams, hand-written
// collision/reset sequences, and randomized backpressure, all checked against a
// model that derives each expected element from the captured matrix and order.
module tb_y_result_streamer;

  localparam int N = 8;
  localparam int W = 2*N+3;

  logic               clk;
  logic               reset;
  logic               done_in;
  logic [64*W-1:0]    y_flat;
  logic               transpose;
  logic [W-1:0]       out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_row;
  logic [2:0]         out_col;
  logic               out_last;
  logic               busy;
  logic               overrun;

  y_result_streamer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .done_in   (done_in),
    .y_flat    (y_flat),
    .transpose (transpose),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;

  logic [W-1:0] cur_m [64];
  int obs_first, obs_second, obs_last;

  typedef struct {
    bit tr;
    int rmode;      // 0 always ready, 1 pattern 1,0,0, 2 random
    int base;       // element (r,c) = base + 8r + c
    int collide;    // element index at which done_in is re-raised, -1 none
    bit exp_ovr;
    int exp_first;
    int exp_second;
    int exp_last;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_matrix(input int base);
    for (int i = 0; i < 64; i++) begin
      if (base < 0) cur_m[i] = W'($urandom());
      else          cur_m[i] = W'(base + i);
      y_flat[i*W +: W] = cur_m[i];
    end
  endtask

  task automatic check_idle(input string tag, input bit exp_ovr);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_row"},   32'(out_row),   32'd0);
    chk({tag, "_col"},   32'(out_col),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_ovr"},   32'(overrun),   32'(exp_ovr));
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    done_in = 1'b0;
    @(negedge clk);
    check_idle("reset", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 1'b0);
  endtask

  // Streams one matrix. With start=1 it raises done_in itself; with start=0
  // the capture edge is expected right after entry using cur_m / tr.
  task automatic run_stream(input bit start, input int base, input bit tr, input int rmode,
                            input int collide_at, input bit rerise, input bit rst20,
                            input bit exp_ovr);
    logic [W-1:0] snap [64];
    logic [W-1:0] h_data;
    logic [2:0]   h_row, h_col;
    logic         h_last;
    int k, kb, cyc, dphase, r, c;
    bit rdy, stalled, rst_now;
    if (start) begin
      done_in = 1'b0;
      @(negedge clk);
      set_matrix(base);
      transpose = tr;
      done_in   = 1'b1;
    end
    for (int i = 0; i < 64; i++) snap[i] = cur_m[i];
    k = 0; cyc = 0; dphase = 0; stalled = 1'b0; rst_now = 1'b0;
    h_data = '0; h_row = 3'd0; h_col = 3'd0; h_last = 1'b0;
    @(negedge clk);
    while (k < 64 && cyc < 1000) begin
      kb = k;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      if (rerise) rdy = 1'b1;
      if (rst20 && k == 20) rdy = 1'b1;
      chk("valid", 32'(out_valid), 32'd1);
      chk("busy",  32'(busy),      32'd1);
      if (stalled) begin
        chk("hold_data", 32'(out_data), 32'(h_data));
        chk("hold_row",  32'(out_row),  32'(h_row));
        chk("hold_col",  32'(out_col),  32'(h_col));
        chk("hold_last", 32'(out_last), 32'(h_last));
      end
      out_ready = rdy;
      transpose = 1'($urandom_range(0, 1));
      if (rdy) begin
        r = tr ? (k % 8) : (k / 8);
        c = tr ? (k / 8) : (k % 8);
        chk("data", 32'(out_data), 32'(snap[8*r + c]));
        chk("row",  32'(out_row),  32'(r));
        chk("col",  32'(out_col),  32'(c));
        chk("last", 32'(out_last), 32'(k == 63));
        if (k == 0)  obs_first  = int'(out_data);
        if (k == 1)  obs_second = int'(out_data);
        if (k == 63) obs_last   = int'(out_data);
        stalled = 1'b0;
        k++;
      end else begin
        stalled = 1'b1;
        h_data = out_data; h_row = out_row; h_col = out_col; h_last = out_last;
      end
      if (collide_at >= 0 && kb == collide_at && dphase == 0) begin
        done_in = 1'b0;
        set_matrix(-1);
        dphase = 1;
      end else if (dphase == 1) begin
        done_in = 1'b1;
        dphase = 2;
      end
      if (rerise && kb == 62) done_in = 1'b0;
      if (rerise && kb == 63) begin
        done_in   = 1'b1;
        set_matrix(100);
        transpose = 1'b0;
      end
      if (rst20 && kb == 20) begin
        reset   = 1'b1;
        rst_now = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (rst_now) begin
        check_idle("midreset", 1'b0);
        set_matrix(200);
        transpose = 1'b1;
        reset     = 1'b0;
        return;
      end
    end
    chk("stream_done", 32'(k), 32'd64);
    if (rmode == 0) chk("cycles", 32'(cyc), 32'd64);
    if (rerise) begin
      chk("rerise_valid", 32'(out_valid), 32'd1);
      chk("rerise_data",  32'(out_data),  32'd100);
      chk("rerise_row",   32'(out_row),   32'd0);
      chk("rerise_col",   32'(out_col),   32'd0);
      chk("rerise_ovr",   32'(overrun),   32'd0);
      out_ready = 1'b0;
    end else begin
      check_idle("end", exp_ovr);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    obs_first = 0; obs_second = 0; obs_last = 0;
    reset = 1'b1; done_in = 1'b0; transpose = 1'b0; out_ready = 1'b0; y_flat = '0;
    for (int i = 0; i < 64; i++) cur_m[i] = '0;

    tbl[0] = '{tr: 1'b0, rmode: 0, base: 0,   collide: -1, exp_ovr: 1'b0, exp_first: 0,   exp_second: 1,   exp_last: 63};
    tbl[1] = '{tr: 1'b1, rmode: 0, base: 0,   collide: -1, exp_ovr: 1'b0, exp_first: 0,   exp_second: 8,   exp_last: 63};
    tbl[2] = '{tr: 1'b0, rmode: 1, base: 300, collide: -1, exp_ovr: 1'b0, exp_first: 300, exp_second: 301, exp_last: 363};
    tbl[3] = '{tr: 1'b1, rmode: 2, base: 500, collide: -1, exp_ovr: 1'b0, exp_first: 500, exp_second: 508, exp_last: 563};
    tbl[4] = '{tr: 1'b0, rmode: 0, base: 0,   collide: 20, exp_ovr: 1'b1, exp_first: 0,   exp_second: 1,   exp_last: 63};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      run_stream(1'b1, tbl[i].base, tbl[i].tr, tbl[i].rmode, tbl[i].collide, 1'b0, 1'b0, tbl[i].exp_ovr);
      chk("tbl_first",  32'(obs_first),  32'(tbl[i].exp_first));
      chk("tbl_second", 32'(obs_second), 32'(tbl[i].exp_second));
      chk("tbl_last",   32'(obs_last),   32'(tbl[i].exp_last));
    end

    // Re-rise exactly on the final transfer: seamless reload, no overrun.
    do_reset();
    run_stream(1'b1, 0, 1'b0, 0, -1, 1'b1, 1'b0, 1'b0);
    run_stream(1'b0, 0, 1'b0, 1, -1, 1'b0, 1'b0, 1'b0);
    chk("reload_first", 32'(obs_first), 32'd100);
    chk("reload_last",  32'(obs_last),  32'd163);

    // Reset on transfer 20; done_in still high makes the first post-reset edge a rise.
    run_stream(1'b1, 40, 1'b1, 2, -1, 1'b0, 1'b1, 1'b0);
    run_stream(1'b0, 0, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
    chk("fresh_first",  32'(obs_first),  32'd200);
    chk("fresh_second", 32'(obs_second), 32'd208);

    // Held done_in: one stream only, then silence.
    run_stream(1'b1, 7, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 136; i++) begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("held_valid", 32'(out_valid), 32'd0);
    end
    chk("held_ovr", 32'(overrun), 32'd0);

    // Randomized matrices, order and backpressure.
    for (int i = 0; i < 4; i++) begin
      run_stream(1'b1, -1, 1'($urandom_range(0, 1)), 2, -1, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
